// File: rtl/pla_cube_eval.sv
// pla_cube_eval: run-time programmable sum-of-products evaluator.
// Each accepted input vector is matched against CUBES_PER_CYC cubes per cycle. Hits OR their
// output masks into the result, which is returned over a valid/ready handshake.
// Latency: E+1 cycles from accept to out_valid, where E = max(1, ceil(ncubes/CUBES_PER_CYC)).
// The latency does not depend on the data. AUTOSYM_XOR_EN adds one more cycle.
// Backpressure: in_ready is high only in IDLE. A result is held in DONE until out_ready.
// Config writes arriving outside IDLE are dropped, and cfg_err pulses on the next cycle.
//
// Optional feature macro: AUTOSYM_XOR_EN. It adds a GF(2) input transform (matrix A) and an
// XFORM state, and adds the cfg_mat_we / cfg_mat_row / cfg_mat_data ports.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   cfg_we/addr/care/val/omask/ncubes   cube write, accepted only in IDLE
//   cfg_err              1-cycle pulse when a config write was dropped
//   in_valid/in_ready/in_x              input vector handshake
//   out_valid/out_ready/out_y           result handshake
module pla_cube_eval #(
  parameter int N_IN          = 21,
  parameter int N_OUT         = 1,
  parameter int N_CUBES       = 64,
  parameter int CUBES_PER_CYC = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(N_CUBES)-1:0]   cfg_addr,
  input  logic [N_IN-1:0]              cfg_care,
  input  logic [N_IN-1:0]              cfg_val,
  input  logic [N_OUT-1:0]             cfg_omask,
  input  logic [$clog2(N_CUBES):0]     cfg_ncubes,
  output logic                         cfg_err,
`ifdef AUTOSYM_XOR_EN
  input  logic                         cfg_mat_we,
  input  logic [$clog2(N_IN)-1:0]      cfg_mat_row,
  input  logic [N_IN-1:0]              cfg_mat_data,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN-1:0]              in_x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_OUT-1:0]             out_y
);

  localparam int AW = $clog2(N_CUBES);
  localparam int BW = AW + 2;  // headroom for base + CUBES_PER_CYC comparisons
  localparam logic [AW:0] MAXC  = (AW+1)'(N_CUBES);
  localparam logic [AW:0] STEP  = (AW+1)'(CUBES_PER_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef AUTOSYM_XOR_EN
    ST_XFORM = 2'd1,
`endif
    ST_EVAL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [N_IN-1:0]  r_care  [N_CUBES];
  logic [N_IN-1:0]  r_val   [N_CUBES];
  logic [N_OUT-1:0] r_omask [N_CUBES];
  logic [AW:0]      r_ncubes;
  logic [AW:0]      r_base;
  logic [N_IN-1:0]  r_x;
  logic [N_OUT-1:0] r_acc;
  logic             r_cfg_err;

  logic             w_idle;
  logic             w_cfg_wr;
  logic             w_cfg_drop;
  logic             w_last;
  logic [N_OUT-1:0] w_hit_or;
  logic [AW:0]      w_ncubes_clamped;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_cfg_wr   = cfg_we && w_idle;
  assign w_ncubes_clamped = (cfg_ncubes > MAXC) ? MAXC : cfg_ncubes;

`ifdef AUTOSYM_XOR_EN
  logic [N_IN-1:0] r_mat [N_IN];
  logic [N_IN-1:0] w_x_xf;
  logic            w_mat_wr;

  assign w_mat_wr   = cfg_mat_we && w_idle;
  assign w_cfg_drop = (cfg_we || cfg_mat_we) && !w_idle;

  // x'[i] is the parity of the bits of x selected by row i of A.
  always_comb begin
    w_x_xf = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_x_xf[i] = ^(r_mat[i] & r_x);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) begin
        r_mat[i] <= N_IN'(1) << i;
      end
    end else if (w_mat_wr && (int'(cfg_mat_row) < N_IN)) begin
      r_mat[cfg_mat_row] <= cfg_mat_data;
    end
  end
`else
  assign w_cfg_drop = cfg_we && !w_idle;
`endif

  // Last EVAL beat once this group reaches ncubes. This also covers ncubes=0, which gives E=1.
  assign w_last = ((BW'(r_base) + BW'(STEP)) >= BW'(r_ncubes));

  // Match the current group of cubes. Slots at or beyond ncubes are masked off.
  always_comb begin
    logic [AW:0] idx;
    w_hit_or = '0;
    idx      = '0;
    for (int j = 0; j < CUBES_PER_CYC; j++) begin
      idx = r_base + (AW+1)'(j);
      if ((idx < r_ncubes) &&
          (((r_x ^ r_val[idx[AW-1:0]]) & r_care[idx[AW-1:0]]) == '0)) begin
        w_hit_or = w_hit_or | r_omask[idx[AW-1:0]];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef AUTOSYM_XOR_EN
          w_state_nxt = ST_XFORM;
`else
          w_state_nxt = ST_EVAL;
`endif
        end
      end
`ifdef AUTOSYM_XOR_EN
      ST_XFORM: w_state_nxt = ST_EVAL;
`endif
      ST_EVAL:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // care/val contents are not reset. With omask cleared and ncubes=0, stale cubes cannot hit.
  always_ff @(posedge clk) begin
    if (!rst && w_cfg_wr) begin
      r_care[cfg_addr] <= cfg_care;
      r_val[cfg_addr]  <= cfg_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ncubes  <= '0;
      r_base    <= '0;
      r_x       <= '0;
      r_acc     <= '0;
      r_cfg_err <= 1'b0;
      for (int k = 0; k < N_CUBES; k++) begin
        r_omask[k] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_err <= w_cfg_drop;
      if (w_cfg_wr) begin
        r_omask[cfg_addr] <= cfg_omask;
        r_ncubes          <= w_ncubes_clamped;
      end
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x    <= in_x;
            r_acc  <= '0;
            r_base <= '0;
          end
        end
`ifdef AUTOSYM_XOR_EN
        ST_XFORM: r_x <= w_x_xf;
`endif
        ST_EVAL: begin
          r_acc  <= r_acc | w_hit_or;
          r_base <= r_base + STEP;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_idle;
  assign out_valid = (r_state == ST_DONE);
  assign out_y     = r_acc;
  assign cfg_err   = r_cfg_err;

endmodule
